// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state, stage indices and flush patterns for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, DROP_FETCH} pctrl_state_t;
  localparam int STG_PC = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_WB = 4;
  localparam logic [4:0] FLUSH_EXCP = 5'b11110;
  localparam logic [4:0] FLUSH_ALL = 5'b11111;
  localparam logic [4:0] STALL_MEM = 5'b01111;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator; register 0 never creates a hazard
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rj_addr,
  input  logic              id_rj_rd,
  input  logic [REG_AW-1:0] id_rk_addr,
  input  logic              id_rk_rd,
  input  logic [REG_AW-1:0] ex_rw_addr,
  input  logic              ex_is_load,
  output logic              load_use
);
  assign load_use = ex_is_load && ex_rw_addr != '0 &&
                    ((id_rj_rd && id_rj_addr == ex_rw_addr) || (id_rk_rd && id_rk_addr == ex_rw_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler with redirect and wrong-path fetch drop.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rj_addr,
  input  logic              id_rj_rd,
  input  logic [REG_AW-1:0] id_rk_addr,
  input  logic              id_rk_rd,
  input  logic [REG_AW-1:0] ex_rw_addr,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              mem_busy,
  input  logic              if_busy,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_target,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  pctrl_state_t state;
  logic load_use, excp, drop;
  logic [ADDR_W-1:0] target, pc_q;
  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .id_rj_addr(id_rj_addr),
    .id_rj_rd(id_rj_rd),
    .id_rk_addr(id_rk_addr),
    .id_rk_rd(id_rk_rd),
    .ex_rw_addr(ex_rw_addr),
    .ex_is_load(ex_is_load),
    .load_use(load_use)
  );
  assign excp = excp_valid && !mem_busy;
  assign drop = state == DROP_FETCH;
  always_comb begin
    stall = '0;
    flush = '0;
    redirect_valid = 1'b0;
    target = excp_target;
    if (rst) begin
      flush = FLUSH_ALL;
    end else if (excp) begin
      flush = FLUSH_EXCP;
      redirect_valid = 1'b1;
    end else if (mem_busy) begin
      stall = STALL_MEM;
      flush[STG_WB] = 1'b1;
      flush[STG_IF_ID] = drop;
    end else if (drop) begin
      stall[STG_PC] = 1'b1;
      flush[STG_IF_ID] = 1'b1;
    end else if (ex_br_taken) begin
      flush[STG_ID_EX:STG_IF_ID] = 2'b11;
      redirect_valid = 1'b1;
      target = ex_br_target;
    end else if (load_use) begin
      stall[STG_IF_ID:STG_PC] = 2'b11;
      flush[STG_ID_EX] = 1'b1;
    end else if (if_busy) begin
      stall[STG_PC] = 1'b1;
      flush[STG_IF_ID] = 1'b1;
    end
  end
  assign redirect_pc = rst ? '0 : redirect_valid ? target : pc_q;
  // a redirect with fetch outstanding must discard that response, even if re-armed by an exception
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_q <= '0;
    end else begin
      if (redirect_valid) pc_q <= target;
      state <= (redirect_valid && if_busy) ? DROP_FETCH : (drop && !if_busy) ? RUN : state;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(stall[STG_PC]);
      flush_count <= flush_count + CNT_W'(redirect_valid);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule
